// File: rtl/mem_pkg.sv
// Shared types and helpers for the data cache.
// Holds funct3 encodings, FSM states and the store lane merge.
package mem_pkg;

    // RV32I funct3 for loads; stores reuse 000/001/010 for SB/SH/SW.
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    // Replace the addressed byte/halfword lanes of old_w with wd.
    function automatic logic [31:0] store_merge(
        input logic [31:0] old_w,
        input logic [31:0] wd,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [31:0] w;
        w = old_w;
        case (f3)
            F3_B:    w[{off, 3'b000} +: 8] = wd[7:0];
            F3_H:    w[{off[1], 4'b0000} +: 16] = wd[15:0];
            F3_W:    w = wd;
            default: w = old_w;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension.
// Ports: i_word (line word), i_offset (A[1:0]), i_funct3, o_rd (extended).
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rd
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_offset, 3'b000} +: 8];
    assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_rd = '0;
        unique case (i_funct3)
            F3_B:    o_rd = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_rd = {{16{w_half[15]}}, w_half};
            F3_W:    o_rd = i_word;
            F3_BU:   o_rd = {24'd0, w_byte};
            F3_HU:   o_rd = {16'd0, w_half};
            default: o_rd = '0;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Ports: clk/rst; MEM-stage A, WD, WE, RE, funct3 -> RD, stall, misaligned;
// data_mem side mem_A, mem_WD, mem_WE, mem_RD; hit_count/miss_count.
module data_cache
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SETS         = 64,
    parameter int MISS_PENALTY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic                  WE,
    input  logic                  RE,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  stall,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic                  mem_WE,
    input  logic [DATA_WIDTH-1:0] mem_RD,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int IW = $clog2(SETS);
    localparam int TW = ADDR_WIDTH - 2 - IW;
    localparam logic [3:0] CNT_INIT = 4'(MISS_PENALTY - 1);

    logic [SETS-1:0]       r_valid;
    logic [TW-1:0]         r_tag  [SETS];
    logic [DATA_WIDTH-1:0] r_data [SETS];
    state_e                r_state;
    state_e                w_next;
    logic [3:0]            r_cnt;
    logic [31:0]           r_hits;
    logic [31:0]           r_misses;

    logic [1:0]            w_off;
    logic [IW-1:0]         w_idx;
    logic [TW-1:0]         w_tag;
    logic                  w_legal;
    logic                  w_half;
    logic                  w_word;
    logic                  w_mis;
    logic                  w_acc;
    logic                  w_st;
    logic                  w_ld;
    logic                  w_hit;
    logic                  w_idle;
    logic                  w_ld_hit;
    logic                  w_ld_miss;
    logic                  w_fill;
    logic [DATA_WIDTH-1:0] w_line;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_off   = A[1:0];
    assign w_idx   = A[2 +: IW];
    assign w_tag   = A[ADDR_WIDTH-1 -: TW];
    assign w_legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    assign w_half  = (funct3[1:0] == 2'b01);
    assign w_word  = (funct3 == F3_W);

    // Reset masks every access so the reset cycle is side-effect free.
    assign w_mis = !rst && (WE || RE) && w_legal &&
                   ((w_half && A[0]) || (w_word && (A[1:0] != 2'b00)));
    assign w_acc = !rst && w_legal && !w_mis;
    assign w_st  = w_acc && WE;
    assign w_ld  = w_acc && RE && !WE;

    assign w_line    = r_data[w_idx];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_idle    = (r_state == IDLE);
    assign w_ld_hit  = w_idle && w_ld && w_hit;
    assign w_ld_miss = w_idle && w_ld && !w_hit;
    assign w_fill    = (r_state == REFILL) && (r_cnt == 4'd0);

    assign misaligned = w_mis;
    assign mem_A      = {A[ADDR_WIDTH-1:2], 2'b00};
    assign mem_WD     = store_merge(mem_RD, WD, w_off, funct3);
    assign hit_count  = r_hits;
    assign miss_count = r_misses;

    load_extend u_ext (
        .i_word   (w_line),
        .i_offset (w_off),
        .i_funct3 (funct3),
        .o_rd     (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_ld_miss)
                r_cnt <= CNT_INIT;
            else if (r_state == REFILL && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_ld_miss) w_next = REFILL;
            REFILL:  if (r_cnt == 4'd0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        stall  = 1'b0;
        mem_WE = 1'b0;
        RD     = '0;
        unique case (r_state)
            IDLE: begin
                stall  = w_ld_miss;
                mem_WE = w_st;
                RD     = w_ld_hit ? w_ext : '0;
            end
            REFILL:  stall = !rst;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_hits   <= 32'd0;
            r_misses <= 32'd0;
        end else begin
            if (w_fill)
                r_valid[w_idx] <= 1'b1;
            if (w_ld_hit && r_hits != 32'hFFFF_FFFF)
                r_hits <= r_hits + 32'd1;
            if (w_ld_miss && r_misses != 32'hFFFF_FFFF)
                r_misses <= r_misses + 32'd1;
        end
    end

    // Tag/data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem_RD;
        end else if (w_idle && w_st && w_hit) begin
            r_data[w_idx] <= store_merge(w_line, WD, w_off, funct3);
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Randomised and directed bench for data_cache.
// Reference: per-line valid/tag table plus a word memory and plain arithmetic.
module tb_data_cache;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] WD = '0;
    logic        WE = 1'b0;
    logic        RE = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] RD;
    logic        stall;
    logic        misaligned;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic [31:0] dmem [4096];
    assign mem_RD = dmem[mem_A[13:2]];

    always #5 clk = ~clk;

    data_cache #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .SETS         (64),
        .MISS_PENALTY (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .WD         (WD),
        .WE         (WE),
        .RE         (RE),
        .funct3     (funct3),
        .RD         (RD),
        .stall      (stall),
        .misaligned (misaligned),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_vec = 0;
    int n_bad = 0;

    bit          mvalid [64];
    logic [31:0] mtag   [64];
    logic [31:0] mhits;
    logic [31:0] mmiss;

    int          o_stalls;
    logic [31:0] o_rd, o_wd, o_a;
    logic        o_we, o_mis;

    int          e_stalls;
    logic [31:0] e_rd, e_wd;
    logic        e_we, e_mis;

    function automatic logic [31:0] m_ext(input logic [31:0] w,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b < 128) ? b : (b | 32'hFFFF_FF00);
            3'd1:    return (h < 32768) ? h : (h | 32'hFFFF_0000);
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old,
                                            input logic [31:0] wd,
                                            input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [31:0] mask;
        case (f3)
            3'd0: begin
                mask = 32'hFF << (8 * off);
                return (old & ~mask) | ((wd & 32'hFF) << (8 * off));
            end
            3'd1: begin
                mask = 32'hFFFF << (16 * off[1]);
                return (old & ~mask) | ((wd & 32'hFFFF) << (16 * off[1]));
            end
            3'd2:    return wd;
            default: return old;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        mhits = 0;
        mmiss = 0;
    endtask

    // Expected outcome of one access; updates the reference cache state.
    task automatic predict(input logic we, input logic re,
                           input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        bit legal, mis, acc;
        int idx;
        logic [31:0] tg, word;
        legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        mis = legal && (we || re) &&
              ((f3[1:0] == 2'b01 && a[0]) || (f3 == 2 && a[1:0] != 0));
        acc = legal && !mis;
        word = dmem[a[13:2]];
        idx = int'(a[7:2]);
        tg = a >> 8;
        e_stalls = 0;
        e_rd = 0;
        e_we = 0;
        e_mis = mis;
        e_wd = m_merge(word, wd, f3, a[1:0]);
        if (acc && we) begin
            e_we = 1;
        end else if (acc && re) begin
            if (!(mvalid[idx] && mtag[idx] == tg)) begin
                e_stalls = P + 1;
                mmiss++;
                mvalid[idx] = 1'b1;
                mtag[idx] = tg;
            end
            mhits++;
            e_rd = m_ext(word, f3, a[1:0]);
        end
    endtask

    task automatic issue(input logic we, input logic re,
                         input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        WE = we;
        RE = re;
        funct3 = f3;
        A = a;
        WD = wd;
        #1;
        o_stalls = 0;
        while (stall === 1'b1 && o_stalls < 40) begin
            o_stalls++;
            @(posedge clk);
            #1;
        end
        o_rd = RD;
        o_wd = mem_WD;
        o_we = mem_WE;
        o_mis = misaligned;
        o_a = mem_A;
        @(posedge clk);
        #1;
        if (o_we === 1'b1) dmem[o_a[13:2]] = o_wd;
        WE = 0;
        RE = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        WE = 1;
        RE = 1;
        funct3 = 3'd2;
        A = 32'h10002;
        #1;
        n_vec++;
        if (stall !== 1'b0 || mem_WE !== 1'b0 || RD !== 32'd0 || misaligned !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: stall=%b we=%b rd=%h mis=%b, want 0 0 0 0",
                     stall, mem_WE, RD, misaligned);
        end
        @(posedge clk);
        #1;
        rst = 0;
        WE = 0;
        RE = 0;
        n_vec++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_counters: hit=%0d miss=%0d, want 0 0", hit_count, miss_count);
        end
        model_reset();
    endtask

    task automatic test_load_miss();
        for (int r = 0; r < 2; r++) begin
            predict(0, 1, 3'd2, 32'h10000, 0);
            issue(0, 1, 3'd2, 32'h10000, 0);
            n_vec++;
            if (o_stalls != (r == 0 ? 3 : 0)) begin
                n_bad++;
                $display("FAIL lw_stall[%0d]: got %0d cycles, want %0d", r, o_stalls,
                         (r == 0 ? 3 : 0));
            end
            n_vec++;
            if (o_rd !== 32'hDEADBEEF) begin
                n_bad++;
                $display("FAIL lw_rd[%0d]: got %h, want deadbeef", r, o_rd);
            end
            n_vec++;
            if (miss_count !== 32'd1 || hit_count !== 32'(r + 1)) begin
                n_bad++;
                $display("FAIL lw_counts[%0d]: hit=%0d miss=%0d, want %0d 1", r,
                         hit_count, miss_count, r + 1);
            end
        end
    endtask

    task automatic test_extend();
        logic [2:0]  f3s [4];
        logic [31:0] as  [4];
        logic [31:0] exs [4];
        f3s = '{3'd0, 3'd4, 3'd1, 3'd5};
        as  = '{32'h10003, 32'h10003, 32'h10002, 32'h10000};
        exs = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            predict(0, 1, f3s[i], as[i], 0);
            issue(0, 1, f3s[i], as[i], 0);
            n_vec++;
            if (o_rd !== exs[i] || o_stalls != 0) begin
                n_bad++;
                $display("FAIL extend[%0d]: rd=%h stalls=%0d, want %h 0", i, o_rd,
                         o_stalls, exs[i]);
            end
        end
    endtask

    task automatic test_store();
        logic [31:0] old;
        predict(1, 0, 3'd0, 32'h10001, 32'h55);
        issue(1, 0, 3'd0, 32'h10001, 32'h55);
        n_vec++;
        if (o_we !== 1'b1 || o_wd !== 32'hDEAD55EF) begin
            n_bad++;
            $display("FAIL sb_hit: we=%b wd=%h, want 1 dead55ef", o_we, o_wd);
        end
        predict(0, 1, 3'd2, 32'h10000, 0);
        issue(0, 1, 3'd2, 32'h10000, 0);
        n_vec++;
        if (o_rd !== 32'hDEAD55EF || o_stalls != 0) begin
            n_bad++;
            $display("FAIL sb_then_lw: rd=%h stalls=%0d, want dead55ef 0", o_rd, o_stalls);
        end
        old = dmem[12'h040];
        predict(1, 0, 3'd1, 32'h10100, 32'hABCD1234);
        issue(1, 0, 3'd1, 32'h10100, 32'hABCD1234);
        n_vec++;
        if (dmem[12'h040] !== {old[31:16], 16'h1234} || o_we !== 1'b1) begin
            n_bad++;
            $display("FAIL sh_miss_write: mem=%h we=%b, want %h 1", dmem[12'h040], o_we,
                     {old[31:16], 16'h1234});
        end
        predict(0, 1, 3'd2, 32'h10100, 0);
        issue(0, 1, 3'd2, 32'h10100, 0);
        n_vec++;
        if (o_stalls != P + 1 || o_rd !== {old[31:16], 16'h1234}) begin
            n_bad++;
            $display("FAIL no_allocate: stalls=%0d rd=%h, want %0d %h", o_stalls, o_rd,
                     P + 1, {old[31:16], 16'h1234});
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] h0, m0;
        logic        wes [4];
        logic        res [4];
        logic [2:0]  f3s [4];
        logic [31:0] as  [4];
        logic        mis [4];
        wes = '{1'b0, 1'b0, 1'b1, 1'b1};
        res = '{1'b1, 1'b1, 1'b0, 1'b1};
        f3s = '{3'd2, 3'd1, 3'd2, 3'd3};
        as  = '{32'h10002, 32'h10001, 32'h10002, 32'h10000};
        mis = '{1'b1, 1'b1, 1'b1, 1'b0};
        h0 = hit_count;
        m0 = miss_count;
        for (int i = 0; i < 4; i++) begin
            predict(wes[i], res[i], f3s[i], as[i], 32'hFFFFFFFF);
            issue(wes[i], res[i], f3s[i], as[i], 32'hFFFFFFFF);
            n_vec++;
            if (o_mis !== mis[i] || o_stalls != 0 || o_we !== 1'b0 || o_rd !== 32'd0) begin
                n_bad++;
                $display("FAIL no_access[%0d]: mis=%b stalls=%0d we=%b rd=%h, want %b 0 0 0",
                         i, o_mis, o_stalls, o_we, o_rd, mis[i]);
            end
        end
        n_vec++;
        if (hit_count !== h0 || miss_count !== m0) begin
            n_bad++;
            $display("FAIL no_access_counts: hit=%0d miss=%0d, want %0d %0d",
                     hit_count, miss_count, h0, m0);
        end
    endtask

    task automatic test_alias();
        logic [31:0] as [3];
        logic [31:0] m0;
        as = '{32'h10000, 32'h10100, 32'h10000};
        predict(0, 1, 3'd2, 32'h10000, 0);
        issue(0, 1, 3'd2, 32'h10000, 0);
        m0 = miss_count;
        for (int i = 1; i < 3; i++) begin
            predict(0, 1, 3'd2, as[i], 0);
            issue(0, 1, 3'd2, as[i], 0);
            n_vec++;
            if (o_stalls != P + 1) begin
                n_bad++;
                $display("FAIL alias[%0d]: stalls=%0d, want %0d", i, o_stalls, P + 1);
            end
        end
        n_vec++;
        if (miss_count !== m0 + 2) begin
            n_bad++;
            $display("FAIL alias_misses: got %0d, want %0d", miss_count, m0 + 2);
        end
    endtask

    task automatic test_reset_refill();
        @(negedge clk);
        WE = 0;
        RE = 1;
        funct3 = 3'd2;
        A = 32'h10200;
        @(posedge clk);
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL refill_stall: got %b, want 1", stall);
        end
        @(negedge clk);
        rst = 1;
        #1;
        n_vec++;
        if (stall !== 1'b0 || mem_WE !== 1'b0 || RD !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_in_refill: stall=%b we=%b rd=%h, want 0 0 0",
                     stall, mem_WE, RD);
        end
        @(posedge clk);
        #1;
        rst = 0;
        RE = 0;
        model_reset();
        #1;
        n_vec++;
        if (stall !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_bad++;
            $display("FAIL after_reset: stall=%b hit=%0d miss=%0d, want 0 0 0",
                     stall, hit_count, miss_count);
        end
        predict(0, 1, 3'd2, 32'h10000, 0);
        issue(0, 1, 3'd2, 32'h10000, 0);
        n_vec++;
        if (o_stalls != P + 1 || miss_count !== 32'd1) begin
            n_bad++;
            $display("FAIL reissue_miss: stalls=%0d miss=%0d, want %0d 1", o_stalls,
                     miss_count, P + 1);
        end
    endtask

    task automatic test_random();
        logic        we, re;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int          kind;
        for (int n = 0; n < 400; n++) begin
            a = 32'h10000 + 4 * $urandom_range(0, 255) + $urandom_range(0, 3);
            wd = $urandom;
            kind = $urandom_range(0, 9);
            we = (kind >= 5 && kind <= 8);
            re = (kind <= 4 || kind == 8);
            if ($urandom_range(0, 11) == 0)
                f3 = 3'd3 + 3'($urandom_range(0, 1) * 3) + 3'($urandom_range(0, 1));
            else if (we)
                f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            if (f3 == 3'd2 && $urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            predict(we, re, f3, a, wd);
            issue(we, re, f3, a, wd);
            n_vec++;
            if (o_stalls != e_stalls || o_mis !== e_mis || o_we !== e_we ||
                o_a !== {a[31:2], 2'b00}) begin
                n_bad++;
                $display("FAIL rand[%0d] ctl a=%h f3=%0d we=%b re=%b: stalls=%0d mis=%b mwe=%b ma=%h, want %0d %b %b %h",
                         n, a, f3, we, re, o_stalls, o_mis, o_we, o_a,
                         e_stalls, e_mis, e_we, {a[31:2], 2'b00});
            end
            if (e_we) begin
                n_vec++;
                if (o_wd !== e_wd) begin
                    n_bad++;
                    $display("FAIL rand[%0d] mem_wd a=%h f3=%0d: got %h, want %h",
                             n, a, f3, o_wd, e_wd);
                end
            end
            if (re) begin
                n_vec++;
                if (o_rd !== e_rd) begin
                    n_bad++;
                    $display("FAIL rand[%0d] rd a=%h f3=%0d: got %h, want %h",
                             n, a, f3, o_rd, e_rd);
                end
            end
        end
        n_vec++;
        if (hit_count !== mhits || miss_count !== mmiss) begin
            n_bad++;
            $display("FAIL rand_counts: hit=%0d miss=%0d, want %0d %0d",
                     hit_count, miss_count, mhits, mmiss);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) dmem[i] = $urandom;
        dmem[0] = 32'hDEADBEEF;
        model_reset();
        test_reset();
        test_load_miss();
        test_extend();
        test_store();
        test_misaligned();
        test_alias();
        test_reset_refill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
